fpu_issue_ctrl: RTL and testbench

//  Execute-stage sequencer on the pipeline side of the FPU. Accepts one decoded FP op

---
 rtl/fpu_issue_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Execute-stage FPU issue sequencer: accepts one decoded FP op, launches it to the core,
// waits for done (bounded by a timeout), and emits a single writeback beat.
//
// state  | meaning
// IDLE   | ready for a new op
// LAUNCH | one-cycle fpu_start pulse; combinational ops complete here
// WAIT   | multi-cycle op in flight, timeout counter running
// DRAIN  | flushed op still busy in the core; wait it out without writeback
// WB     | one-cycle writeback strobe
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int REG_AW         = 5
) (
    input  logic              g_clk,
    input  logic              g_rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_sel,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_int_dest,
    input  logic [31:0]       id_rs1,
    input  logic [31:0]       id_rs2,
    input  logic [31:0]       id_rs3,
    input  logic              flush,
    output logic [31:0]       fpu_a,
    output logic [31:0]       fpu_b,
    output logic [31:0]       fpu_c,
    output logic [4:0]        fpu_sel,
    output logic              fpu_start,
    input  logic              fpu_done,
    input  logic [31:0]       fpu_res,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [31:0]       wb_data,
    output logic              wb_int,
    output logic              stall,
    output logic              err_timeout,
    output logic [15:0]       op_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam int          CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [31:0] QNAN    = 32'h7fc0_0000;

    function automatic logic is_comb(input logic [4:0] s);
        return (s >= 5'd5) && (s <= 5'd15);
    endfunction

    function automatic logic is_unsup(input logic [4:0] s);
        return (s == 5'd4) || (s >= 5'd24);
    endfunction

    logic [2:0]        r_state;
    logic [4:0]        r_sel;
    logic [REG_AW-1:0] r_rd;
    logic              r_int;
    logic [31:0]       r_a, r_b, r_c;
    logic [CW-1:0]     r_cnt;
    logic [31:0]       r_wb_data;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_int;
    logic              r_err;
    logic [15:0]       r_op_count;

    logic w_comb;
    logic w_tc;

    assign w_comb = is_comb(r_sel);
    // >= rather than == so a counter that was pushed past the limit still terminates
    assign w_tc   = (r_cnt >= CNT_TO);

    always_ff @(posedge g_clk) begin
        if (!g_rst) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_rd       <= '0;
            r_int      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_cnt      <= '0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_wb_int   <= 1'b0;
            r_err      <= 1'b0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (id_valid && !flush) begin
                        r_sel <= id_sel;
                        r_rd  <= id_rd;
                        r_int <= id_int_dest;
                        r_a   <= id_rs1;
                        r_b   <= id_rs2;
                        r_c   <= id_rs3;
                        if (is_unsup(id_sel)) begin
                            r_wb_data <= QNAN;
                            r_wb_rd   <= id_rd;
                            r_wb_int  <= id_int_dest;
                            r_state   <= S_WB;
                        end else begin
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (flush) begin
                        r_cnt   <= CNT_ONE;
                        r_state <= w_comb ? S_IDLE : S_DRAIN;
                    end else if (w_comb || fpu_done) begin
                        r_wb_data <= fpu_res;
                        r_wb_rd   <= r_rd;
                        r_wb_int  <= r_int;
                        r_state   <= S_WB;
                    end else begin
                        r_cnt   <= CNT_ONE;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        if (!w_tc) r_cnt <= r_cnt + CNT_ONE;
                        r_state <= S_DRAIN;
                    end else if (fpu_done) begin
                        r_wb_data <= fpu_res;
                        r_wb_rd   <= r_rd;
                        r_wb_int  <= r_int;
                        r_state   <= S_WB;
                    end else if (w_tc) begin
                        r_wb_data <= QNAN;
                        r_wb_rd   <= r_rd;
                        r_wb_int  <= r_int;
                        r_err     <= 1'b1;
                        r_state   <= S_WB;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (fpu_done) begin
                        r_state <= S_IDLE;
                    end else if (w_tc) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WB: begin
                    if (!flush) r_op_count <= r_op_count + 16'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign id_ready    = (r_state == S_IDLE);
    assign stall       = id_valid && !id_ready;
    assign fpu_start   = (r_state == S_LAUNCH);
    assign fpu_a       = r_a;
    assign fpu_b       = r_b;
    assign fpu_c       = r_c;
    assign fpu_sel     = r_sel;
    assign wb_valid    = (r_state == S_WB) && !flush;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_int      = r_wb_int;
    assign err_timeout = r_err;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: multi-cycle, combinational, unsupported, timeout,
// flush/drain and mid-op reset scenarios with hand-computed expectations.
module tb_fpu_issue_ctrl;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_sel;
    logic [4:0]  id_rd;
    logic        id_int_dest;
    logic [31:0] id_rs1, id_rs2, id_rs3;
    logic        flush;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic [4:0]  fpu_sel;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_int;
    logic        stall;
    logic        err_timeout;
    logic [15:0] op_count;

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    int n_wb    = 0;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(8), .REG_AW(5)) dut (
        .g_clk(g_clk), .g_rst(g_rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_sel(id_sel), .id_rd(id_rd),
        .id_int_dest(id_int_dest), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .flush(flush),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_sel(fpu_sel),
        .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_res(fpu_res),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_int(wb_int),
        .stall(stall), .err_timeout(err_timeout), .op_count(op_count)
    );

    always #5 g_clk = ~g_clk;

    always @(negedge g_clk) begin
        if (fpu_start) n_start++;
        if (wb_valid)  n_wb++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic present(input logic [4:0] sel, input logic [4:0] rd, input logic intd,
                           input logic [31:0] a, input logic [31:0] b);
        id_valid    = 1'b1;
        id_sel      = sel;
        id_rd       = rd;
        id_int_dest = intd;
        id_rs1      = a;
        id_rs2      = b;
        id_rs3      = 32'h0;
    endtask

    int start_base;
    int wb_base;

    initial begin
        g_rst = 1'b0; id_valid = 1'b0; id_sel = '0; id_rd = '0; id_int_dest = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rs3 = '0; flush = 1'b0; fpu_done = 1'b0; fpu_res = '0;

        // reset state
        cyc(); cyc();
        id_valid = 1'b1; #1;
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        id_valid = 1'b0;
        g_rst = 1'b1;
        cyc();

        // 1: FADD, done four cycles after start
        present(5'b00000, 5'd3, 1'b0, 32'h3f800000, 32'h40000000);
        cyc();
        id_valid = 1'b0; #1;
        chk("t1_start", 32'(fpu_start), 32'd1);
        chk("t1_fpu_a", fpu_a, 32'h3f800000);
        chk("t1_fpu_b", fpu_b, 32'h40000000);
        chk("t1_ready_busy", 32'(id_ready), 32'd0);
        cyc(); chk("t1_start_once", 32'(fpu_start), 32'd0);
        cyc(); cyc(); cyc();
        fpu_done = 1'b1; fpu_res = 32'h40400000; #1;
        chk("t1_no_early_wb", 32'(wb_valid), 32'd0);
        cyc();
        fpu_done = 1'b0; #1;
        chk("t1_wb_valid", 32'(wb_valid), 32'd1);
        chk("t1_wb_data", wb_data, 32'h40400000);
        chk("t1_wb_rd", 32'(wb_rd), 32'd3);
        chk("t1_wb_int", 32'(wb_int), 32'd0);
        cyc();
        chk("t1_wb_pulse", 32'(wb_valid), 32'd0);
        chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_wb_hold", wb_data, 32'h40400000);
        chk("t1_n_start", 32'(n_start), 32'd1);

        // 2: FEQ (combinational), id_valid held
        present(5'b01010, 5'd7, 1'b1, 32'h3f800000, 32'h3f800000);
        cyc();
        fpu_res = 32'h1; #1;
        chk("t2_start", 32'(fpu_start), 32'd1);
        chk("t2_stall_launch", 32'(stall), 32'd1);
        cyc();
        chk("t2_wb_valid", 32'(wb_valid), 32'd1);
        chk("t2_wb_data", wb_data, 32'h1);
        chk("t2_wb_int", 32'(wb_int), 32'd1);
        chk("t2_wb_rd", 32'(wb_rd), 32'd7);
        chk("t2_stall_wb", 32'(stall), 32'd1);
        cyc();
        id_valid = 1'b0; #1;
        chk("t2_op_count", 32'(op_count), 32'd2);

        // flushed op in IDLE is not accepted
        start_base = n_start;
        present(5'b00000, 5'd1, 1'b0, 32'h1, 32'h2);
        flush = 1'b1;
        cyc();
        id_valid = 1'b0; flush = 1'b0; #1;
        chk("flush_idle_ready", 32'(id_ready), 32'd1);
        cyc();
        chk("flush_idle_no_start", 32'(n_start), 32'(start_base));

        // 5: unsupported op
        start_base = n_start;
        present(5'b00100, 5'd9, 1'b0, 32'haaaa5555, 32'h0);
        cyc();
        id_valid = 1'b0; #1;
        chk("t5_no_start", 32'(fpu_start), 32'd0);
        chk("t5_wb_valid", 32'(wb_valid), 32'd1);
        chk("t5_wb_data", wb_data, 32'h7fc00000);
        chk("t5_wb_rd", 32'(wb_rd), 32'd9);
        cyc();
        chk("t5_n_start", 32'(n_start), 32'(start_base));
        chk("t5_op_count", 32'(op_count), 32'd3);

        // 3: FDIV timeout after 8 WAIT cycles
        present(5'b00011, 5'd4, 1'b0, 32'h40800000, 32'h40000000);
        cyc();
        id_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t3_wait_no_wb", 32'(wb_valid), 32'd0);
        end
        chk("t3_err_before", 32'(err_timeout), 32'd0);
        cyc();
        chk("t3_wb_valid", 32'(wb_valid), 32'd1);
        chk("t3_wb_data", wb_data, 32'h7fc00000);
        chk("t3_wb_rd", 32'(wb_rd), 32'd4);
        chk("t3_err", 32'(err_timeout), 32'd1);
        cyc();
        chk("t3_op_count", 32'(op_count), 32'd4);
        present(5'b00101, 5'd1, 1'b0, 32'h1, 32'h2);
        cyc();
        id_valid = 1'b0; fpu_res = 32'h12345678;
        cyc();
        chk("t3_good_wb", wb_data, 32'h12345678);
        chk("t3_err_sticky", 32'(err_timeout), 32'd1);
        cyc();
        chk("t3_good_count", 32'(op_count), 32'd5);

        // 4: FMUL flushed in WAIT, done 3 cycles later
        start_base = n_start;
        wb_base    = n_wb;
        present(5'b00010, 5'd5, 1'b0, 32'h40400000, 32'h40400000);
        cyc();
        id_valid = 1'b0;
        cyc();
        cyc();
        flush = 1'b1; #1;
        chk("t4_flush_no_wb", 32'(wb_valid), 32'd0);
        cyc();
        flush = 1'b0; #1;
        chk("t4_drain_ready", 32'(id_ready), 32'd0);
        cyc();
        chk("t4_drain_ready2", 32'(id_ready), 32'd0);
        cyc();
        fpu_done = 1'b1; fpu_res = 32'h41100000;
        cyc();
        fpu_done = 1'b0; #1;
        chk("t4_ready_after_done", 32'(id_ready), 32'd1);
        cyc();
        chk("t4_no_wb", 32'(n_wb), 32'(wb_base));
        chk("t4_one_start", 32'(n_start), 32'(start_base + 1));
        chk("t4_op_count", 32'(op_count), 32'd5);

        // 6: reset during WAIT
        wb_base = n_wb;
        present(5'b00010, 5'd6, 1'b0, 32'h3f000000, 32'h3f000000);
        cyc();
        id_valid = 1'b0;
        cyc();
        cyc();
        g_rst = 1'b0;
        cyc();
        g_rst = 1'b1; #1;
        chk("t6_ready", 32'(id_ready), 32'd1);
        chk("t6_wb_valid", 32'(wb_valid), 32'd0);
        chk("t6_op_count", 32'(op_count), 32'd0);
        chk("t6_err", 32'(err_timeout), 32'd0);
        chk("t6_fpu_a", fpu_a, 32'd0);
        fpu_done = 1'b1; fpu_res = 32'h3e800000;
        cyc();
        fpu_done = 1'b0;
        cyc();
        cyc();
        chk("t6_no_wb", 32'(n_wb), 32'(wb_base));
        chk("t6_op_count_after", 32'(op_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
